// File: rtl/apb_master_bridge.sv
// Single-outstanding APB initiator: turns valid/ready requests into SETUP/ACCESS
// transfers and reports completion, read data or a PREADY timeout on a response port.
module apb_master_bridge #(
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error,
    output logic              PSELx,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic              PREADY,
    input  logic [DATA_W-1:0] PRDATA
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic             ready_int;
    logic             accept;
    logic             done;
    logic             timed_out;

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        ready_int = 1'b0;
        PSELx     = 1'b0;
        PENABLE   = 1'b0;
        done      = 1'b0;
        timed_out = 1'b0;
        case (state)
            IDLE: begin
                ready_int = 1'b1;
                if (req_valid) state_nxt = SETUP;
            end
            SETUP: begin
                PSELx     = 1'b1;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                PSELx   = 1'b1;
                PENABLE = 1'b1;
                if (PREADY) begin
                    done      = 1'b1;
                    ready_int = 1'b1;
                    state_nxt = req_valid ? SETUP : IDLE;
                end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                    timed_out = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Held low while reset is asserted so no request is taken during reset.
    assign req_ready = ready_int & PRESETn;
    assign accept    = req_valid & req_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state <= IDLE;
        else          state <= state_nxt;
    end

    // Counter restarts on every acceptance and stops one short of TIMEOUT, so it never wraps.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wait_cnt <= '0;
        end else if (accept) begin
            wait_cnt <= '0;
        end else if (state == ACCESS && !PREADY && !timed_out) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            PWRITE <= 1'b0;
            PADDR  <= '0;
            PWDATA <= '0;
        end else if (accept) begin
            PWRITE <= req_write;
            PADDR  <= req_addr;
            PWDATA <= req_wdata;
        end
    end

    // Response data and error hold between pulses; only a finishing transfer updates them.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rsp_valid <= 1'b0;
            rsp_error <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= done | timed_out;
            if (done | timed_out) begin
                rsp_error <= timed_out;
                rsp_rdata <= (done && !PWRITE) ? PRDATA : '0;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: write, waited read, back-to-back,
// timeout abort, reset mid-transfer and address/data hold.
module tb_apb_master_bridge;

    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 16;

    logic              PCLK;
    logic              PRESETn;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_error;
    logic              PSELx;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic              PREADY;
    logic [DATA_W-1:0] PRDATA;

    int checks = 0;
    int errors = 0;

    apb_master_bridge #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error),
        .PSELx    (PSELx),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PREADY   (PREADY),
        .PRDATA   (PRDATA)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle before sampling or driving.
    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    initial begin
        PRESETn   = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        PREADY    = 1'b0;
        PRDATA    = '0;

        #3;
        check("rst_psel",    PSELx,     0);
        check("rst_penable", PENABLE,   0);
        check("rst_ready",   req_ready, 0);
        check("rst_rspv",    rsp_valid, 0);
        check("rst_paddr",   PADDR,     0);
        check("rst_pwdata",  PWDATA,    0);
        check("rst_pwrite",  PWRITE,    0);
        check("rst_rdata",   rsp_rdata, 0);
        check("rst_err",     rsp_error, 0);
        tick();
        tick();
        PRESETn = 1'b1;
        #1;
        check("idle_ready", req_ready, 1);

        // Single write, zero wait states.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 7'h02; req_wdata = 8'hA5;
        PREADY = 1'b1; PRDATA = 8'hC3;
        tick();
        req_valid = 1'b0;
        check("w_setup_psel",    PSELx,     1);
        check("w_setup_penable", PENABLE,   0);
        check("w_setup_ready",   req_ready, 0);
        check("w_setup_paddr",   PADDR,     7'h02);
        check("w_setup_pwdata",  PWDATA,    8'hA5);
        check("w_setup_pwrite",  PWRITE,    1);
        tick();
        check("w_acc_psel",    PSELx,     1);
        check("w_acc_penable", PENABLE,   1);
        check("w_acc_ready",   req_ready, 1);
        check("w_acc_rspv",    rsp_valid, 0);
        tick();
        check("w_rsp_valid", rsp_valid, 1);
        check("w_rsp_err",   rsp_error, 0);
        check("w_rsp_rdata", rsp_rdata, 0);
        check("w_idle_psel", PSELx,     0);
        check("w_hold_addr", PADDR,     7'h02);
        tick();
        check("w_rsp_pulse", rsp_valid, 0);

        // Read with 3 wait states; request inputs change during the transfer.
        PREADY = 1'b0; PRDATA = 8'h99;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 7'h05; req_wdata = 8'h00;
        tick();
        req_valid = 1'b0; req_addr = 7'h7F; req_wdata = 8'hFF; req_write = 1'b1;
        check("r_setup_penable", PENABLE, 0);
        check("r_setup_paddr",   PADDR,   7'h05);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("r_wait_penable", PENABLE,   1);
            check("r_wait_ready",   req_ready, 0);
            check("r_wait_rspv",    rsp_valid, 0);
            check("r_hold_paddr",   PADDR,     7'h05);
            check("r_hold_pwdata",  PWDATA,    8'h00);
            check("r_hold_pwrite",  PWRITE,    0);
        end
        PREADY = 1'b1; PRDATA = 8'h3C;
        #1;
        check("r_last_penable", PENABLE,   1);
        check("r_last_ready",   req_ready, 1);
        tick();
        PRDATA = 8'h00;
        check("r_rsp_valid", rsp_valid, 1);
        check("r_rsp_rdata", rsp_rdata, 8'h3C);
        check("r_rsp_err",   rsp_error, 0);
        check("r_idle_en",   PENABLE,   0);
        tick();
        check("r_rsp_pulse", rsp_valid, 0);
        check("r_rdata_hold", rsp_rdata, 8'h3C);

        // Back-to-back: write 8'h11 to 7'h01, then read 7'h03.
        PREADY = 1'b1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 7'h01; req_wdata = 8'h11;
        tick();
        check("b_s1_psel",    PSELx,   1);
        check("b_s1_penable", PENABLE, 0);
        req_write = 1'b0; req_addr = 7'h03; req_wdata = 8'h22;
        tick();
        check("b_a1_psel",    PSELx,     1);
        check("b_a1_penable", PENABLE,   1);
        check("b_a1_paddr",   PADDR,     7'h01);
        check("b_a1_pwdata",  PWDATA,    8'h11);
        check("b_a1_ready",   req_ready, 1);
        tick();
        req_valid = 1'b0; PRDATA = 8'h5A;
        check("b_s2_psel",    PSELx,     1);
        check("b_s2_penable", PENABLE,   0);
        check("b_s2_paddr",   PADDR,     7'h03);
        check("b_s2_pwrite",  PWRITE,    0);
        check("b_rsp1_valid", rsp_valid, 1);
        check("b_rsp1_rdata", rsp_rdata, 0);
        tick();
        check("b_a2_psel",    PSELx,     1);
        check("b_a2_penable", PENABLE,   1);
        check("b_gap_rspv",   rsp_valid, 0);
        tick();
        check("b_rsp2_valid", rsp_valid, 1);
        check("b_rsp2_rdata", rsp_rdata, 8'h5A);
        check("b_rsp2_err",   rsp_error, 0);
        check("b_end_psel",   PSELx,     0);

        // Timeout: PREADY held low with junk on PRDATA.
        PREADY = 1'b0; PRDATA = 8'hEE;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 7'h0A;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) begin
            tick();
            check("t_wait_penable", PENABLE,   1);
            check("t_wait_rspv",    rsp_valid, 0);
        end
        tick();
        check("t_abort_psel",    PSELx,     0);
        check("t_abort_penable", PENABLE,   0);
        check("t_rsp_valid",     rsp_valid, 1);
        check("t_rsp_err",       rsp_error, 1);
        check("t_rsp_rdata",     rsp_rdata, 0);
        check("t_idle_ready",    req_ready, 1);

        // Normal transfer after the timeout.
        PREADY = 1'b1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 7'h04; req_wdata = 8'h77;
        tick();
        req_valid = 1'b0;
        check("n_setup_penable", PENABLE, 0);
        check("n_setup_rspv",    rsp_valid, 0);
        tick();
        check("n_acc_penable", PENABLE, 1);
        tick();
        check("n_rsp_valid", rsp_valid, 1);
        check("n_rsp_err",   rsp_error, 0);
        check("n_rsp_rdata", rsp_rdata, 0);

        // Reset asserted during an ACCESS wait state.
        PREADY = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 7'h06;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        check("m_pre_penable", PENABLE, 1);
        #2;
        PRESETn = 1'b0;
        #1;
        check("m_async_psel",    PSELx,     0);
        check("m_async_penable", PENABLE,   0);
        check("m_async_rspv",    rsp_valid, 0);
        check("m_async_paddr",   PADDR,     0);
        PREADY = 1'b1;
        tick();
        check("m_rst_rspv",  rsp_valid, 0);
        check("m_rst_ready", req_ready, 0);
        PRESETn = 1'b1;
        #1;
        check("m_rel_ready", req_ready, 1);
        check("m_rel_psel",  PSELx,     0);
        tick();
        check("m_rel_rspv",  rsp_valid, 0);
        check("m_rel_psel2", PSELx,     0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Single-outstanding APB initiator that drives the I2C controller's APB register interface from a simple valid/ready request port; the source is a sequencer, CPU shim or bench driver.
- It converts each request into an APB SETUP phase followed by an ACCESS phase, waits for PREADY and returns read data or a timeout error on a response port.
- It sits upstream of the I2C APB register slave and is clocked on PCLK.

Parameters:
- ADDR_W, 7, APB address width (PADDR).
- DATA_W, 8, APB data width (PWDATA/PRDATA).
- TIMEOUT, 16, maximum ACCESS cycles to wait for PREADY before aborting; legal range 2..255.

Ports:
- PCLK  input  1  clock; all logic on rising edge.
- PRESETn  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted this cycle when req_valid and req_ready are both high.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  target register address.
- req_wdata  input  DATA_W  write data; ignored for reads.
- rsp_valid  output  1  one-cycle pulse: transfer finished.
- rsp_rdata  output  DATA_W  read data; 0 for writes and on error.
- rsp_error  output  1  qualifies rsp_valid; 1 = timeout abort.
- PSELx  output  1  APB select.
- PENABLE  output  1  APB enable.
- PWRITE  output  1  APB direction.
- PADDR  output  ADDR_W  APB address.
- PWDATA  output  DATA_W  APB write data.
- PREADY  input  1  slave ready.
- PRDATA  input  DATA_W  slave read data.

Behaviour:
- Reset (async, PRESETn low):
  - State goes to IDLE; wait counter cleared.
  - PSELx, PENABLE, PWRITE, req_ready, rsp_valid, rsp_error = 0; PADDR, PWDATA, rsp_rdata = 0.
  - Asserting reset mid-transfer drops PSELx/PENABLE immediately; no response is emitted for the aborted transfer.
- States: IDLE, SETUP, ACCESS.
- IDLE:
  - req_ready = 1 (combinational on state).
  - On req_valid, latch req_write/req_addr/req_wdata into PWRITE/PADDR/PWDATA and go to SETUP.
- SETUP: exactly one cycle; PSELx = 1, PENABLE = 0; go to ACCESS unconditionally.
- ACCESS:
  - PSELx = 1, PENABLE = 1.
  - Sample PREADY each rising edge.
  - PREADY = 1: transfer completes. Pulse rsp_valid with rsp_error = 0 the next cycle. rsp_rdata = PRDATA captured at that edge if PWRITE = 0, else 0.
  - PREADY = 0: increment the wait counter.
- Timeout: if PREADY is still 0 on the TIMEOUT-th ACCESS cycle, abort. PSELx and PENABLE go low the next cycle, and rsp_valid pulses with rsp_error = 1 and rsp_rdata = 0.
- Back-to-back:
  - req_ready is also 1 in ACCESS during the cycle PREADY = 1.
  - If req_valid is high then, the new request is latched and the next state is SETUP: PSELx stays 1, PENABLE goes 0.
  - Otherwise return to IDLE.
  - req_ready = 0 in SETUP and in ACCESS while PREADY = 0.
- Minimum transfer is 2 cycles (SETUP + ACCESS with no wait states). Latency from acceptance to rsp_valid is 2 + wait states cycles.
- Hold rule: PADDR, PWDATA and PWRITE are stable from SETUP through the end of ACCESS. After completion they hold their last value until the next acceptance; they do not return to 0.
- Responses: rsp_valid is a single-cycle pulse with no back-pressure; the consumer must capture it. rsp_rdata and rsp_error are valid only while rsp_valid = 1 and hold otherwise.
- Wait counter: width ceil(log2(TIMEOUT+1)); reset to 0 on each SETUP entry; never wraps.
- PRDATA is ignored outside ACCESS and for writes.
- req_valid is sampled only when req_ready = 1; request inputs may change freely at all other times.

Test Plan:
- Reset then single write: req (write=1, addr=7'h02, wdata=8'hA5), slave PREADY tied 1 -> SETUP cycle with PSELx=1/PENABLE=0, then ACCESS with PADDR=7'h02/PWDATA=8'hA5/PWRITE=1; rsp_valid pulse, rsp_error=0, rsp_rdata=0; total 2 cycles.
- Read with 3 wait states: req (write=0, addr=7'h05), PREADY low 3 ACCESS cycles then high with PRDATA=8'h3C -> PENABLE high for 4 cycles, rsp_rdata=8'h3C, rsp_error=0.
- Back-to-back: two requests presented continuously (write 8'h11 to 7'h01, read 7'h03) -> PSELx never deasserts between them; PENABLE pattern 0,1,0,1; two rsp_valid pulses exactly 2 cycles apart.
- Timeout: TIMEOUT=16, PREADY held 0 -> PENABLE high for exactly 16 cycles then PSELx=0; rsp_valid=1, rsp_error=1, rsp_rdata=0; next request proceeds normally.
- Reset mid-ACCESS: PRESETn low during a wait state -> PSELx/PENABLE=0 asynchronously, no rsp_valid; after release req_ready=1 in IDLE.
- Hold check: change req_addr/req_wdata while in SETUP/ACCESS -> PADDR/PWDATA stay at their latched values throughout the transfer.
